pe_input_feeder: RTL and testbench



---
 rtl/pe_input_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_pe_input_feeder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_input_feeder.sv
// pe_input_feeder
//   Streams K operand vectors from the local operand buffer into the PE array
//   with diagonal skew (lane i delayed by i cycles). It also drives a
//   contiguous en pulse to the status controller and raises a one-cycle done
//   after the last skewed element has left the last lane.
//
//   Optional build macro: FEEDER_PERF_CNT_EN adds the perf_cycles[15:0]
//   output. This is a saturating count of busy cycles for the most recent job.

module pe_input_feeder #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     data_flow,
    input  logic [ADDR_W-1:0]        k_len,
    output logic                     busy,
    output logic                     done,
`ifdef FEEDER_PERF_CNT_EN
    output logic [15:0]              perf_cycles,
`endif
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [ROWS*DATA_W-1:0]   rd_data_a,
    input  logic [COLS*DATA_W-1:0]   rd_data_b,
    output logic [ROWS*DATA_W-1:0]   a_out,
    output logic [COLS*DATA_W-1:0]   b_out,
    output logic                     en_out
);

    // Flush depth: the deepest skew lane across both buses.
    localparam int D       = (ROWS > COLS) ? ROWS : COLS;
    localparam int FLUSH_W = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   k_q;        // job length captured on accepted start
    logic                ws_q;       // 1: weight-stationary, B bus held at zero
    logic [FLUSH_W-1:0]  flush_cnt;

    // Job sequencer: accepts start in IDLE, issues reads, waits for the skew
    // chain to drain, then pulses done. All control outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_q       <= '0;
            ws_q      <= 1'b0;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge value of state/rd_addr regardless of statement order.
            case (state)
                IDLE: begin
                    if (start) begin
                        k_q  <= k_len;
                        ws_q <= data_flow;
                        busy <= 1'b1;
                        if (k_len == '0) begin
                            // Empty job: no reads and no en, just the done pulse.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                end

                FETCH: begin
                    // rd_addr is the address counter itself. It stops at
                    // k_len-1 and so never wraps, even for the largest k_len.
                    if (rd_addr == k_q - ADDR_W'(1)) begin
                        state     <= FLUSH;
                        rd_en     <= 1'b0;
                        rd_addr   <= '0;
                        flush_cnt <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end

                FLUSH: begin
                    if (flush_cnt == FLUSH_W'(D - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end

                DONE: begin
                    // A start seen here is dropped: the FSM only samples
                    // start in IDLE.
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    // en_out marks the cycles in which buffer data is valid. The buffer has
    // one cycle of read latency, so en_out is rd_en delayed by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_out <= 1'b0;
        end else begin
            en_out <= rd_en;
        end
    end

`ifdef FEEDER_PERF_CNT_EN
    // Busy-cycle counter: cleared by an accepted start, saturating, and held
    // between jobs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
        end else if (busy && perf_cycles != 16'hFFFF) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

    // A-bus skew. Lane i takes element i of the incoming vector, gated to zero
    // outside the en window, and delays it by i cycles. Lane 0 has no delay.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
        logic [DATA_W-1:0] lane_in;
        assign lane_in = en_out ? rd_data_a[i*DATA_W +: DATA_W] : '0;

        if (i == 0) begin : g_pass
            assign a_out[i*DATA_W +: DATA_W] = lane_in;
        end else begin : g_dly
            logic [DATA_W-1:0] dly [i];

            // Shift every cycle, so zeros flush the lane once en_out drops.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    // NOTE: the skew stages are reset explicitly. Otherwise the
                    // PE array would see stale operands right after reset.
                    for (int s = 0; s < i; s++) dly[s] <= '0;
                end else begin
                    dly[0] <= lane_in;
                    for (int s = 1; s < i; s++) dly[s] <= dly[s-1];
                end
            end

            assign a_out[i*DATA_W +: DATA_W] = dly[i-1];
        end
    end

    // B-bus skew. Same structure as the A bus. The lane input is also gated
    // off for a weight-stationary job, so b_out stays zero for the whole job.
    for (genvar i = 0; i < COLS; i++) begin : g_b_lane
        logic [DATA_W-1:0] lane_in;
        assign lane_in = (en_out && !ws_q) ? rd_data_b[i*DATA_W +: DATA_W] : '0;

        if (i == 0) begin : g_pass
            assign b_out[i*DATA_W +: DATA_W] = lane_in;
        end else begin : g_dly
            logic [DATA_W-1:0] dly [i];

            // Shift every cycle, matching the A lane of the same depth.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) dly[s] <= '0;
                end else begin
                    dly[0] <= lane_in;
                    for (int s = 1; s < i; s++) dly[s] <= dly[s-1];
                end
            end

            assign b_out[i*DATA_W +: DATA_W] = dly[i-1];
        end
    end

endmodule

// File: tb/tb_pe_input_feeder.sv
// Testbench for pe_input_feeder (ROWS=COLS=DATA_W=ADDR_W=8).
// A scoreboard queue holds one expected record per clock cycle. Each record
// is pushed when the stimulus is driven and popped by the monitor on the
// falling edge.

module tb_pe_input_feeder;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int D      = 8;   // max(ROWS, COLS)

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic                    data_flow;
    logic [ADDR_W-1:0]       k_len;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [ROWS*DATA_W-1:0]  rd_data_a;
    logic [COLS*DATA_W-1:0]  rd_data_b;
    logic [ROWS*DATA_W-1:0]  a_out;
    logic [COLS*DATA_W-1:0]  b_out;
    logic                    en_out;
`ifdef FEEDER_PERF_CNT_EN
    logic [15:0]             perf_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string             tag;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic              en_out;
        logic [63:0]       a;
        logic [63:0]       b;
        logic              busy;
        logic              done;
    } exp_t;

    exp_t sb[$];

    pe_input_feeder #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_flow  (data_flow),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
`ifdef FEEDER_PERF_CNT_EN
        .perf_cycles(perf_cycles),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .a_out      (a_out),
        .b_out      (b_out),
        .en_out     (en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffer model with one cycle of read latency. Unread cycles return
    // a junk pattern, so any missing gating shows up as nonzero lanes.
    always @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            rd_data_a[i*DATA_W +: DATA_W] <= rd_en ? 8'(16 * int'(rd_addr) + i) : 8'hEE;
            rd_data_b[i*DATA_W +: DATA_W] <= rd_en ? 8'(128 + 16 * int'(rd_addr) + i) : 8'hDD;
        end
    end

    function automatic exp_t idle_rec(input string tag);
        exp_t r;
        r.tag = tag; r.rd_en = 1'b0; r.rd_addr = '0; r.en_out = 1'b0;
        r.a = '0; r.b = '0; r.busy = 1'b0; r.done = 1'b0;
        return r;
    endfunction

    // Expected outputs at cycle c, where c = 0 is the cycle of the first rd_en.
    function automatic exp_t job_rec(input int k, input bit ws, input int c);
        exp_t r;
        r = idle_rec($sformatf("k%0d_ws%0d_c%0d", k, ws, c));
        if (k == 0) begin
            r.busy = 1'b1;
            r.done = 1'b1;
            return r;
        end
        r.rd_en   = (c >= 0 && c < k);
        r.rd_addr = r.rd_en ? ADDR_W'(c) : '0;
        r.en_out  = (c >= 1 && c <= k);
        for (int i = 0; i < ROWS; i++) begin
            int j;
            j = c - 1 - i;
            if (j >= 0 && j < k) begin
                r.a[i*8 +: 8] = 8'(16 * j + i);
                r.b[i*8 +: 8] = ws ? 8'h00 : 8'(128 + 16 * j + i);
            end
        end
        r.busy = (c >= 0 && c <= k + D);
        r.done = (c == k + D);
        return r;
    endfunction

    // Scoreboard consumer: one record per cycle while records are queued.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (rd_en !== e.rd_en || (e.rd_en && rd_addr !== e.rd_addr) ||
                en_out !== e.en_out || a_out !== e.a || b_out !== e.b ||
                busy !== e.busy || done !== e.done) begin
                miscompares++;
                $display("FAIL %s: got rd_en=%b addr=%h en=%b a=%h b=%h busy=%b done=%b, want rd_en=%b addr=%h en=%b a=%h b=%h busy=%b done=%b",
                         e.tag, rd_en, rd_addr, en_out, a_out, b_out, busy, done,
                         e.rd_en, e.rd_addr, e.en_out, e.a, e.b, e.busy, e.done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sb.push_back(idle_rec($sformatf("%s_idle%0d", tag, i)));
            tick();
        end
    endtask

    // Starts a job in the current cycle and runs it until the cycle after
    // done. g1 and g2 pulse a spurious start in job cycle c == g (-1 = none).
    task automatic run_job(input int k, input bit ws, input int g1, input int g2);
        int last;
        last = (k == 0) ? 0 : k + D;
        start = 1'b1; k_len = ADDR_W'(k); data_flow = ws;
        sb.push_back(idle_rec($sformatf("k%0d_ws%0d_start", k, ws)));
        for (int c = 0; c <= last; c++) sb.push_back(job_rec(k, ws, c));
        tick();
        for (int c = 0; c <= last; c++) begin
            if (c == g1 || c == g2) begin
                start = 1'b1; k_len = 8'd2; data_flow = ~ws;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; data_flow = 1'b0; k_len = '0;
        tick();
        tick();
        vectors++;
        if ({busy, done, rd_en, en_out} !== 4'b0 || rd_addr !== '0 ||
            a_out !== '0 || b_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b en=%b addr=%h a=%h b=%h, want all 0",
                     busy, done, rd_en, en_out, rd_addr, a_out, b_out);
        end
`ifdef FEEDER_PERF_CNT_EN
        vectors++;
        if (perf_cycles !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_perf: got %0d want 0", perf_cycles);
        end
`endif
        rst_n = 1'b1;
        idle_cycles(4, "post_reset");
    endtask

    task automatic test_os_job();
        run_job(4, 1'b0, -1, -1);
        sb.push_back(idle_rec("os_after"));
`ifdef FEEDER_PERF_CNT_EN
        vectors++;
        if (perf_cycles !== 16'd13) begin
            miscompares++;
            $display("FAIL perf_after_k4: got %0d want 13", perf_cycles);
        end
`endif
        tick();
`ifdef FEEDER_PERF_CNT_EN
        vectors++;
        if (perf_cycles !== 16'd13) begin
            miscompares++;
            $display("FAIL perf_hold: got %0d want 13", perf_cycles);
        end
`endif
    endtask

    task automatic test_ws_job();
        run_job(3, 1'b1, -1, -1);
        idle_cycles(2, "ws");
    endtask

    task automatic test_k_zero();
        run_job(0, 1'b0, -1, -1);
        idle_cycles(3, "k0");
    endtask

    task automatic test_start_ignored();
        // Spurious starts in FETCH (c=1) and in the done cycle (c=4+D).
        run_job(4, 1'b0, 1, 4 + D);
        idle_cycles(4, "ignored");
    endtask

    task automatic test_back_to_back();
        run_job(2, 1'b0, -1, -1);
        run_job(3, 1'b1, -1, -1);
        run_job(5, 1'b0, -1, -1);
        idle_cycles(2, "b2b");
    endtask

    task automatic test_max_len();
        run_job(255, 1'b0, -1, -1);
        idle_cycles(2, "max");
    endtask

    task automatic test_reset_in_flush();
        start = 1'b1; k_len = 8'd4; data_flow = 1'b0;
        sb.push_back(idle_rec("rstflush_start"));
        for (int c = 0; c <= 6; c++) sb.push_back(job_rec(4, 1'b0, c));
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        // Cycle 6 of the job is the third FLUSH cycle.
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({busy, done, rd_en, en_out} !== 4'b0 || a_out !== '0 || b_out !== '0) begin
            miscompares++;
            $display("FAIL reset_in_flush: got busy=%b done=%b rd_en=%b en=%b a=%h b=%h, want all 0",
                     busy, done, rd_en, en_out, a_out, b_out);
        end
`ifdef FEEDER_PERF_CNT_EN
        vectors++;
        if (perf_cycles !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_in_flush_perf: got %0d want 0", perf_cycles);
        end
`endif
        rst_n = 1'b1;
        idle_cycles(16, "after_abort");
    endtask

    initial begin
        test_reset();
        test_os_job();
        test_ws_job();
        test_k_zero();
        test_start_ignored();
        test_back_to_back();
        test_max_len();
        test_reset_in_flush();
        tick();
        tick();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d records left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
